mux_sel_scanner: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_next_ch.sv | 30 +++
 rtl/mux_sel_scanner.sv | 150 +++++++++++++++
 tb/tb_mux_sel_scanner.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the 4:1 mux select scanner.
//   NUM_CH    - number of mux input channels
//   SEL_W     - width of the mux select {S1,S0}
//   state_t   - scanner FSM states
//   ch_mask_t - one bit per channel (enable mask / sampled word)
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  typedef logic [NUM_CH-1:0] ch_mask_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: combinational channel picker for the scanner.
// Ports:
//   start - 1: return the lowest enabled channel; 0: return the lowest
//           enabled channel strictly above cur
//   mask  - channel enable mask
//   cur   - current channel
//   nxt   - selected channel (0 when none found)
//   found - a qualifying enabled channel exists
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic             start,
  input  ch_mask_t         mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && mask[i] && (start || (i > 32'(cur)))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: drives the select lines of a downstream 4:1 mux, stepping
// in ascending order through the enabled channels, holding each select for
// DWELL cycles and sampling MUX_OUT on the last one. A complete scan is
// published atomically on SAMPLE with a one-cycle SAMPLE_VLD strobe.
// Parameters:
//   DWELL - cycles the select is held per channel (1..2**CNT_W)
//   CNT_W - width of the dwell down-counter
// Ports:
//   CLK        - clock, rising edge
//   RST        - synchronous active-high reset
//   EN         - scan enable; dropping it mid-scan aborts the scan
//   CH_EN[3:0] - channel enable mask, latched at scan start
//   MUX_OUT    - output of the downstream mux
//   S1, S0     - mux select
//   SAMPLE     - last completed scan result, bit n = channel n
//   SAMPLE_VLD - one-cycle pulse when SAMPLE updates
//   BUSY       - scan in progress
//   CHG        - pulses with SAMPLE_VLD when SAMPLE changed value
// Optional: define MUX_SCAN_CHANGE_DETECT_EN to build the change detector;
// otherwise CHG is tied low.
module mux_sel_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] CH_EN,
  input  logic       MUX_OUT,
  output logic       S1,
  output logic       S0,
  output logic [3:0] SAMPLE,
  output logic       SAMPLE_VLD,
  output logic       BUSY,
  output logic       CHG
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] sel, sel_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  ch_mask_t         mask, mask_n;
  ch_mask_t         shadow, shadow_n;
  ch_mask_t         sample, sample_n;
  ch_mask_t         captured;
  logic             vld, vld_n;
  logic             idle;
  logic [SEL_W-1:0] nxt_ch;
  logic             nxt_found;

  assign idle = (state == IDLE);

  // In IDLE the picker looks at the live mask to find the first channel;
  // during a scan it walks the mask latched at scan start.
  mux_scan_next_ch u_next_ch (
    .start (idle),
    .mask  (idle ? CH_EN : mask),
    .cur   (sel),
    .nxt   (nxt_ch),
    .found (nxt_found)
  );

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    cnt_n    = cnt;
    mask_n   = mask;
    shadow_n = shadow;
    sample_n = sample;
    vld_n    = 1'b0;
    captured = shadow;
    captured[sel] = MUX_OUT;

    case (state)
      IDLE: begin
        if (EN && (CH_EN != '0)) begin
          mask_n   = CH_EN;
          shadow_n = '0;
          sel_n    = nxt_ch;
          cnt_n    = RELOAD;
          state_n  = mux_scan_pkg::DWELL;
        end
      end
      default: begin
        if (!EN) begin
          // abort: partial results dropped, SAMPLE untouched
          state_n  = IDLE;
          shadow_n = '0;
          sel_n    = '0;
          cnt_n    = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          shadow_n = captured;
          if (nxt_found) begin
            sel_n = nxt_ch;
            cnt_n = RELOAD;
          end else begin
            sample_n = captured;
            vld_n    = 1'b1;
            state_n  = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      sel    <= '0;
      cnt    <= '0;
      mask   <= '0;
      shadow <= '0;
      sample <= '0;
      vld    <= 1'b0;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      cnt    <= cnt_n;
      mask   <= mask_n;
      shadow <= shadow_n;
      sample <= sample_n;
      vld    <= vld_n;
    end
  end

`ifdef MUX_SCAN_CHANGE_DETECT_EN
  logic chg;

  // compared against the outgoing SAMPLE, which is 0000 after reset
  always_ff @(posedge CLK) begin
    if (RST) chg <= 1'b0;
    else     chg <= vld_n && (captured != sample);
  end

  assign CHG = chg;
`else
  assign CHG = 1'b0;
`endif

  assign {S1, S0}   = sel;
  assign SAMPLE     = sample;
  assign SAMPLE_VLD = vld;
  assign BUSY       = ~idle;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed bench for mux_sel_scanner: three instances (DWELL=4, 2, 1) share
// the control inputs; each one's mux is modelled as din[{S1,S0}].
module tb_mux_sel_scanner;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [3:0] CH_EN;
  logic [3:0] din;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef MUX_SCAN_CHANGE_DETECT_EN
  localparam logic CHG_ON = 1'b1;
`else
  localparam logic CHG_ON = 1'b0;
`endif

  always #5 CLK = ~CLK;

  logic a_s1, a_s0, a_vld, a_busy, a_chg, a_mux;
  logic b_s1, b_s0, b_vld, b_busy, b_chg, b_mux;
  logic c_s1, c_s0, c_vld, c_busy, c_chg, c_mux;
  logic [3:0] a_sample, b_sample, c_sample;

  assign a_mux = din[{a_s1, a_s0}];
  assign b_mux = din[{b_s1, b_s0}];
  assign c_mux = din[{c_s1, c_s0}];

  mux_sel_scanner #(.DWELL(4), .CNT_W(8)) u_dut_a (
    .CLK(CLK), .RST(RST), .EN(EN), .CH_EN(CH_EN), .MUX_OUT(a_mux),
    .S1(a_s1), .S0(a_s0), .SAMPLE(a_sample), .SAMPLE_VLD(a_vld),
    .BUSY(a_busy), .CHG(a_chg)
  );

  mux_sel_scanner #(.DWELL(2), .CNT_W(8)) u_dut_b (
    .CLK(CLK), .RST(RST), .EN(EN), .CH_EN(CH_EN), .MUX_OUT(b_mux),
    .S1(b_s1), .S0(b_s0), .SAMPLE(b_sample), .SAMPLE_VLD(b_vld),
    .BUSY(b_busy), .CHG(b_chg)
  );

  mux_sel_scanner #(.DWELL(1), .CNT_W(8)) u_dut_c (
    .CLK(CLK), .RST(RST), .EN(EN), .CH_EN(CH_EN), .MUX_OUT(c_mux),
    .S1(c_s1), .S0(c_s0), .SAMPLE(c_sample), .SAMPLE_VLD(c_vld),
    .BUSY(c_busy), .CHG(c_chg)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; CH_EN = 4'b0000; din = 4'b0000;
    step(); step();
    total_cnt++;
    if ({a_s1, a_s0, a_busy, a_vld, a_chg, a_sample} !== 9'b0)
      $display("FAIL reset_a: got %b expected %b", {a_s1, a_s0, a_busy, a_vld, a_chg, a_sample}, 9'b0);
    else pass_cnt++;
    total_cnt++;
    if ({b_s1, b_s0, b_busy, b_vld, b_chg, b_sample} !== 9'b0)
      $display("FAIL reset_b: got %b expected %b", {b_s1, b_s0, b_busy, b_vld, b_chg, b_sample}, 9'b0);
    else pass_cnt++;
    total_cnt++;
    if ({c_s1, c_s0, c_busy, c_vld, c_chg, c_sample} !== 9'b0)
      $display("FAIL reset_c: got %b expected %b", {c_s1, c_s0, c_busy, c_vld, c_chg, c_sample}, 9'b0);
    else pass_cnt++;
    RST = 1'b0;
  endtask

  // edge 0 = IDLE exit; selects 00,01,10,11 for 4 edges each, strobe at 16
  task automatic test_full_scan();
    logic [1:0] exp_sel;
    din = 4'b1010; CH_EN = 4'b1111; EN = 1'b1;
    for (int n = 0; n < 16; n++) begin
      step();
      exp_sel = 2'(n / 4);
      total_cnt++;
      if ({a_s1, a_s0, a_busy, a_vld} !== {exp_sel, 1'b1, 1'b0})
        $display("FAIL full_scan_sel edge %0d: got %b expected %b", n, {a_s1, a_s0, a_busy, a_vld}, {exp_sel, 1'b1, 1'b0});
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({a_busy, a_vld, a_chg, a_sample} !== {1'b0, 1'b1, CHG_ON, 4'b1010})
      $display("FAIL full_scan_done: got %b expected %b", {a_busy, a_vld, a_chg, a_sample}, {1'b0, 1'b1, CHG_ON, 4'b1010});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({a_s1, a_s0, a_busy, a_vld, a_chg, a_sample} !== {2'b00, 1'b1, 1'b0, 1'b0, 4'b1010})
      $display("FAIL full_scan_restart: got %b expected %b", {a_s1, a_s0, a_busy, a_vld, a_chg, a_sample}, {2'b00, 1'b1, 1'b0, 1'b0, 4'b1010});
    else pass_cnt++;
    EN = 1'b0;
    step();
    total_cnt++;
    if ({a_s1, a_s0, a_busy, a_vld} !== 4'b0000)
      $display("FAIL full_scan_stop: got %b expected %b", {a_s1, a_s0, a_busy, a_vld}, 4'b0000);
    else pass_cnt++;
  endtask

  // identical scan -> no change; then I2 toggled and CH_EN changed mid-scan
  task automatic test_change_detect();
    int k;
    EN = 1'b1;
    k = 0;
    do begin step(); k++; end while (!a_vld && k < 40);
    total_cnt++;
    if ({a_vld, a_chg, a_sample} !== {1'b1, 1'b0, 4'b1010})
      $display("FAIL chg_same: got %b expected %b", {a_vld, a_chg, a_sample}, {1'b1, 1'b0, 4'b1010});
    else pass_cnt++;
    din = 4'b1110;
    step();
    CH_EN = 4'b0001;
    k = 0;
    do begin step(); k++; end while (!a_vld && k < 40);
    total_cnt++;
    if (k !== 16)
      $display("FAIL chg_period: got %0d edges expected %0d", k, 16);
    else pass_cnt++;
    total_cnt++;
    if ({a_vld, a_chg, a_sample} !== {1'b1, CHG_ON, 4'b1110})
      $display("FAIL chg_diff: got %b expected %b", {a_vld, a_chg, a_sample}, {1'b1, CHG_ON, 4'b1110});
    else pass_cnt++;
    EN = 1'b0; CH_EN = 4'b1111;
    step();
    total_cnt++;
    if ({a_busy, a_vld, a_chg, a_sample} !== {3'b000, 4'b1110})
      $display("FAIL chg_after: got %b expected %b", {a_busy, a_vld, a_chg, a_sample}, {3'b000, 4'b1110});
    else pass_cnt++;
  endtask

  task automatic test_abort();
    din = 4'b0101; EN = 1'b1;
    step();
    for (int n = 0; n < 9; n++) step();
    total_cnt++;
    if ({a_s1, a_s0, a_busy} !== 3'b101)
      $display("FAIL abort_on_ch2: got %b expected %b", {a_s1, a_s0, a_busy}, 3'b101);
    else pass_cnt++;
    EN = 1'b0;
    step();
    total_cnt++;
    if ({a_s1, a_s0, a_busy, a_vld, a_sample} !== {4'b0000, 4'b1110})
      $display("FAIL abort_next: got %b expected %b", {a_s1, a_s0, a_busy, a_vld, a_sample}, {4'b0000, 4'b1110});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({a_vld, a_sample} !== {1'b0, 4'b1110})
      $display("FAIL abort_hold: got %b expected %b", {a_vld, a_sample}, {1'b0, 4'b1110});
    else pass_cnt++;
  endtask

  // DWELL=2, mask 1010, all inputs high: disabled channels must read 0
  task automatic test_skip();
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd1; exp_sel[2] = 2'd3; exp_sel[3] = 2'd3;
    din = 4'b1111; CH_EN = 4'b1010; EN = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      total_cnt++;
      if ({b_s1, b_s0, b_busy, b_vld} !== {exp_sel[n], 1'b1, 1'b0})
        $display("FAIL skip_sel edge %0d: got %b expected %b", n, {b_s1, b_s0, b_busy, b_vld}, {exp_sel[n], 1'b1, 1'b0});
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({b_busy, b_vld, b_sample} !== {1'b0, 1'b1, 4'b1010})
      $display("FAIL skip_done: got %b expected %b", {b_busy, b_vld, b_sample}, {1'b0, 1'b1, 4'b1010});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({b_s1, b_s0, b_busy, b_vld} !== 4'b0110)
      $display("FAIL skip_restart: got %b expected %b", {b_s1, b_s0, b_busy, b_vld}, 4'b0110);
    else pass_cnt++;
    for (int n = 0; n < 4; n++) step();
    total_cnt++;
    if ({b_vld, b_sample} !== {1'b1, 4'b1010})
      $display("FAIL skip_period: got %b expected %b", {b_vld, b_sample}, {1'b1, 4'b1010});
    else pass_cnt++;
    EN = 1'b0; CH_EN = 4'b1111;
    step();
  endtask

  task automatic test_dwell_one();
    din = 4'b0110; CH_EN = 4'b1111; EN = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      total_cnt++;
      if ({c_s1, c_s0, c_busy, c_vld} !== {2'(n), 1'b1, 1'b0})
        $display("FAIL dwell1_sel edge %0d: got %b expected %b", n, {c_s1, c_s0, c_busy, c_vld}, {2'(n), 1'b1, 1'b0});
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({c_busy, c_vld, c_sample} !== {1'b0, 1'b1, 4'b0110})
      $display("FAIL dwell1_done: got %b expected %b", {c_busy, c_vld, c_sample}, {1'b0, 1'b1, 4'b0110});
    else pass_cnt++;
    EN = 1'b0;
    step();
  endtask

  task automatic test_empty_mask();
    int bad;
    CH_EN = 4'b0000; EN = 1'b1;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if ({a_busy, a_vld} !== 2'b00) bad++;
    end
    total_cnt++;
    if (bad !== 0)
      $display("FAIL empty_mask_idle: got %0d active cycles expected %0d", bad, 0);
    else pass_cnt++;
    CH_EN = 4'b0001;
    step();
    total_cnt++;
    if ({a_s1, a_s0, a_busy, a_vld} !== 4'b0010)
      $display("FAIL empty_mask_start: got %b expected %b", {a_s1, a_s0, a_busy, a_vld}, 4'b0010);
    else pass_cnt++;
    EN = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_scan();
    CH_EN = 4'b1111; EN = 1'b1; din = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) step();
    total_cnt++;
    if ({a_s1, a_s0, a_busy} !== 3'b011)
      $display("FAIL rst_mid_pre: got %b expected %b", {a_s1, a_s0, a_busy}, 3'b011);
    else pass_cnt++;
    RST = 1'b1;
    step();
    total_cnt++;
    if ({a_s1, a_s0, a_busy, a_vld, a_chg, a_sample} !== 9'b0)
      $display("FAIL rst_mid: got %b expected %b", {a_s1, a_s0, a_busy, a_vld, a_chg, a_sample}, 9'b0);
    else pass_cnt++;
    RST = 1'b0; EN = 1'b0;
    step();
    total_cnt++;
    if ({a_vld, a_busy, a_sample} !== 6'b0)
      $display("FAIL rst_mid_after: got %b expected %b", {a_vld, a_busy, a_sample}, 6'b0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_change_detect();
    test_abort();
    test_skip();
    test_dwell_one();
    test_empty_mask();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
